instr_sequencer: RTL

- Program store and fetch/execute sequencer for the 8-bit datapath.
- Holds a small instruction memory loaded over a write port, and presents the word at the datapath's current PC.
- Issues one datapath clock-enable pulse per instruction.
- Supports free-run, single-step and halt, so the datapath advances only under controller command instead of free-running off its own divided clock.

---
 rtl/seq_pkg.sv | 28 ++
 rtl/prog_rom.sv | 53 +++++
 rtl/instr_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
//   Shared definitions for the instruction sequencer:
//     - seq_state_e : sequencer state encoding, also driven on the state port
//                     (00 IDLE, 01 FETCH, 10 EXEC, 11 HALT)
//     - NOP_INSTR_DEFAULT / DEPTH_DEFAULT / AW_DEFAULT : parameter defaults
//     - sat_inc8    : saturating 8-bit increment for the executed-instr count
// -----------------------------------------------------------------------------
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_HALT  = 2'b11
  } seq_state_e;

  localparam logic [7:0]  NOP_INSTR_DEFAULT = 8'h00;
  localparam int unsigned DEPTH_DEFAULT     = 16;
  localparam int unsigned AW_DEFAULT        = 4;
  localparam logic [7:0]  CNT_MAX           = 8'hFF;

  // Counter sticks at CNT_MAX instead of wrapping back to zero.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/prog_rom.sv
// -----------------------------------------------------------------------------
// prog_rom
//   DEPTH x 8 program store with a synchronous write port and a registered
//   read port. The read register doubles as the instruction register seen by
//   the datapath: it only loads when rd_en_i is high, holds otherwise, and is
//   forced to CLR_WORD by rd_clr_i.
//
//   clk_i      : clock
//   wr_en_i    : write strobe
//   wr_addr_i  : write address
//   wr_data_i  : write data
//   rd_en_i    : load read register from mem[rd_addr_i]
//   rd_addr_i  : read address
//   rd_clr_i   : synchronous clear of read register (wins over rd_en_i)
//   rd_data_o  : registered read data
// -----------------------------------------------------------------------------
module prog_rom #(
  parameter int         DEPTH    = 16,
  parameter int         AW       = 4,
  parameter logic [7:0] CLR_WORD = 8'h00
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  input  logic          rd_clr_i,
  output logic [7:0]    rd_data_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_data_q;

  // NOTE: the storage array deliberately has no reset: a program must survive
  // a sequencer reset, and a reset-free array maps onto plain RAM cells.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rd_clr_i) begin
      rd_data_q <= CLR_WORD;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//   Program store plus fetch/execute sequencer for the 8-bit datapath. The
//   datapath only advances when this block pulses dp_en (one pulse per
//   instruction), under run / single-step / halt control.
//
//   _CLK        : system clock, all state on posedge
//   RESET       : synchronous active-low reset (memory contents kept)
//   load_en     : program write strobe (honoured in IDLE only)
//   load_addr   : program write address
//   load_data   : program write data
//   run         : level, continuous execution
//   step        : pulse, execute one instruction
//   halt_req    : pulse, stop after the current instruction
//   restart     : pulse, HALT -> IDLE
//   PC          : datapath program counter
//   instruction : word presented to the datapath (NOP_INSTR when none held)
//   dp_en       : datapath clock enable, high for the EXEC cycle
//   state       : 00 IDLE, 01 FETCH, 10 EXEC, 11 HALT
//   halted      : high in HALT
//   prog_len    : highest written address + 1
//   instr_cnt   : executed instructions since reset, saturating at 255
// -----------------------------------------------------------------------------
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int         DEPTH     = DEPTH_DEFAULT,
  parameter int         AW        = AW_DEFAULT,
  parameter logic [7:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic          _CLK,
  input  logic          RESET,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [7:0]    load_data,
  input  logic          run,
  input  logic          step,
  input  logic          halt_req,
  input  logic          restart,
  input  logic [7:0]    PC,
  output logic [7:0]    instruction,
  output logic          dp_en,
  output logic [1:0]    state,
  output logic          halted,
  output logic [AW:0]   prog_len,
  output logic [7:0]    instr_cnt
);

  seq_state_e  state_q,     state_d;
  logic        step_mode_q, step_mode_d;
  logic        halt_pend_q, halt_pend_d;
  logic [AW:0] prog_len_q,  prog_len_d;
  logic [7:0]  instr_cnt_q, instr_cnt_d;
  logic        dp_en_q;
  logic        halted_q;

  logic        pc_in_range;
  logic [AW:0] load_len;
  logic        rom_wr_en;
  logic        rom_rd_en;
  logic        rom_clr;

  // Full 8-bit PC against prog_len: any PC at or beyond DEPTH is out of range,
  // so upper PC bits never alias onto low memory addresses.
  assign pc_in_range = ({1'b0, PC} < 9'(prog_len_q));

  // Length implied by a write to load_addr (AW+1 bits so DEPTH fits).
  assign load_len = {1'b0, load_addr} + {{AW{1'b0}}, 1'b1};

  // Memory is only writable while IDLE; a write in the same cycle as run/step
  // lands on the IDLE->FETCH edge, so the following fetch already sees it.
  assign rom_wr_en = RESET && (state_q == ST_IDLE) && load_en;
  assign rom_rd_en = RESET && (state_q == ST_FETCH) && pc_in_range;
  assign rom_clr   = !RESET || ((state_q == ST_FETCH) && !pc_in_range);

  prog_rom #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .CLR_WORD (NOP_INSTR)
  ) u_prog_rom (
    .clk_i     (_CLK),
    .wr_en_i   (rom_wr_en),
    .wr_addr_i (load_addr),
    .wr_data_i (load_data),
    .rd_en_i   (rom_rd_en),
    .rd_addr_i (PC[AW-1:0]),
    .rd_clr_i  (rom_clr),
    .rd_data_o (instruction)
  );

  // NOTE: every next-state variable gets a default at the top of the block;
  // without it a path that skips an assignment would infer a latch.
  always_comb begin
    state_d     = state_q;
    step_mode_d = step_mode_q;
    halt_pend_d = halt_pend_q;
    prog_len_d  = prog_len_q;
    instr_cnt_d = instr_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (load_en && (load_len > prog_len_q)) begin
          prog_len_d = load_len;
        end
        // run has priority: run+step together starts a continuous run.
        if (run) begin
          state_d     = ST_FETCH;
          step_mode_d = 1'b0;
        end else if (step) begin
          state_d     = ST_FETCH;
          step_mode_d = 1'b1;
        end
      end

      ST_FETCH: begin
        if (halt_req) begin
          halt_pend_d = 1'b1;
        end
        state_d = pc_in_range ? ST_EXEC : ST_HALT;
      end

      ST_EXEC: begin
        // The instruction is already issued; a halt request only decides
        // where we go next, it never cancels this dp_en pulse.
        instr_cnt_d = sat_inc8(instr_cnt_q);
        halt_pend_d = 1'b0;
        if (halt_pend_q || halt_req) begin
          state_d = ST_HALT;
        end else if (step_mode_q) begin
          state_d = ST_IDLE;
        end else if (run) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_HALT: begin
        if (restart) begin
          state_d     = ST_IDLE;
          halt_pend_d = 1'b0;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge _CLK) begin
    if (!RESET) begin
      state_q     <= ST_IDLE;
      step_mode_q <= 1'b0;
      halt_pend_q <= 1'b0;
      prog_len_q  <= '0;
      instr_cnt_q <= '0;
      dp_en_q     <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_mode_q <= step_mode_d;
      halt_pend_q <= halt_pend_d;
      prog_len_q  <= prog_len_d;
      instr_cnt_q <= instr_cnt_d;
      // Outputs registered from the next state so they line up with state_q.
      dp_en_q     <= (state_d == ST_EXEC);
      halted_q    <= (state_d == ST_HALT);
    end
  end

  assign dp_en     = dp_en_q;
  assign halted    = halted_q;
  assign state     = state_q;
  assign prog_len  = prog_len_q;
  assign instr_cnt = instr_cnt_q;

endmodule
